// File: rtl/elevator_scan_ctrl.sv
// SCAN-scheduled elevator car controller for an N-floor shaft: latches calls,
// keeps direction while requests remain ahead, timed floor moves and door dwell.
module elevator_scan_ctrl #(
  parameter int FLOORS     = 3,
  parameter int FW         = $clog2(FLOORS),
  parameter int TRAVEL_CYC = 4,
  parameter int DOOR_CYC   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] call_req,
  output logic [FW-1:0]     current_floor,
  output logic [FLOORS-1:0] pending,
  output logic              up_led,
  output logic              down_led,
  output logic              door_open,
  output logic              moving
);

  localparam int CMAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TRAVEL_CYC - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DOOR_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

  state_t          state;
  logic            dir_up;
  logic [CW-1:0]   tcnt;
  logic [CW-1:0]   dcnt;

  logic [FLOORS-1:0] req;
  logic [FLOORS-1:0] clr;
  logic [FW-1:0]     nxt;
  logic              above;
  logic              below;
  logic              beyond;
  logic              hit_cur;
  logic              hit_nxt;
  logic              arrive;

  // Calls presented this cycle count as requests immediately, so an idle car
  // reacts on the same edge the call is sampled.
  always_comb begin
    req    = pending | call_req;
    nxt    = dir_up ? current_floor + FW'(1) : current_floor - FW'(1);
    above  = 1'b0;
    below  = 1'b0;
    beyond = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (req[i] && (i > int'(current_floor))) above = 1'b1;
      if (req[i] && (i < int'(current_floor))) below = 1'b1;
      if (req[i] && (dir_up ? (i > int'(nxt)) : (i < int'(nxt)))) beyond = 1'b1;
    end
    hit_cur = req[current_floor];
    hit_nxt = req[nxt];
    arrive  = (state == S_MOVE) && (tcnt == T_LAST);

    clr = '0;
    case (state)
      S_IDLE:  if (hit_cur) clr[current_floor] = 1'b1;
      S_MOVE:  if (arrive && hit_nxt) clr[nxt] = 1'b1;
      // With the door open, a call for this floor is absorbed rather than latched.
      S_DOOR:  clr[current_floor] = 1'b1;
      default: clr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      dir_up        <= 1'b1;
      current_floor <= '0;
      pending       <= '0;
      tcnt          <= '0;
      dcnt          <= '0;
      up_led        <= 1'b0;
      down_led      <= 1'b0;
      door_open     <= 1'b0;
      moving        <= 1'b0;
    end else begin
      pending <= req & ~clr;
      case (state)
        S_IDLE: begin
          tcnt <= '0;
          dcnt <= '0;
          if (hit_cur) begin
            state     <= S_DOOR;
            door_open <= 1'b1;
          end else if (above && (dir_up || !below)) begin
            state  <= S_MOVE;
            dir_up <= 1'b1;
            moving <= 1'b1;
            up_led <= 1'b1;
          end else if (below) begin
            state    <= S_MOVE;
            dir_up   <= 1'b0;
            moving   <= 1'b1;
            down_led <= 1'b1;
          end
        end

        S_MOVE: begin
          dcnt <= '0;
          if (arrive) begin
            current_floor <= nxt;
            tcnt          <= '0;
            if (hit_nxt) begin
              state     <= S_DOOR;
              door_open <= 1'b1;
              moving    <= 1'b0;
              up_led    <= 1'b0;
              down_led  <= 1'b0;
            end else if (!beyond) begin
              state    <= S_IDLE;
              moving   <= 1'b0;
              up_led   <= 1'b0;
              down_led <= 1'b0;
            end
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end

        S_DOOR: begin
          tcnt <= '0;
          // A fresh call for this floor keeps the door open for a full dwell.
          if (call_req[current_floor]) begin
            dcnt <= '0;
          end else if (dcnt == D_LAST) begin
            state     <= S_IDLE;
            door_open <= 1'b0;
            dcnt      <= '0;
          end else begin
            dcnt <= dcnt + CW'(1);
          end
        end

        default: begin
          state     <= S_IDLE;
          tcnt      <= '0;
          dcnt      <= '0;
          moving    <= 1'b0;
          up_led    <= 1'b0;
          down_led  <= 1'b0;
          door_open <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl on a 4-floor shaft: expected stops (floor, door-open
// cycle, dwell length) are queued at stimulus time and popped when the door opens.
module tb_elevator_scan_ctrl;

  localparam int FLOORS = 4;
  localparam int FW     = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [FLOORS-1:0] call_req = '0;
  logic [FW-1:0]     current_floor;
  logic [FLOORS-1:0] pending;
  logic              up_led;
  logic              down_led;
  logic              door_open;
  logic              moving;

  elevator_scan_ctrl #(
    .FLOORS(FLOORS), .FW(FW), .TRAVEL_CYC(4), .DOOR_CYC(3)
  ) dut (
    .clk(clk), .rst(rst), .call_req(call_req), .current_floor(current_floor),
    .pending(pending), .up_led(up_led), .down_led(down_led),
    .door_open(door_open), .moving(moving)
  );

  always #5 clk = ~clk;

  typedef struct {
    int floor;
    int cyc;
    int len;
  } stop_t;

  stop_t sb_q[$];
  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  int    door_len = 0;
  int    exp_len = 0;
  logic  door_prev = 1'b0;
  int    max_floor = 0;
  logic  down_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Stop monitor: pops one expectation per door opening, checks the dwell on close.
  always @(negedge clk) begin
    if (rst) begin
      door_prev = 1'b0;
      door_len  = 0;
      max_floor = 0;
      down_seen = 1'b0;
    end else begin
      if (int'(current_floor) > max_floor) max_floor = int'(current_floor);
      if (down_led) down_seen = 1'b1;
      if (door_open && !door_prev) begin
        door_len = 1;
        if (sb_q.size() == 0) begin
          chk("unexpected_stop", sb_q.size(), 1);
          exp_len = 0;
        end else begin
          stop_t e;
          e = sb_q.pop_front();
          chk("stop_floor", current_floor, e.floor);
          chk("stop_cycle", cyc, e.cyc);
          exp_len = e.len;
        end
      end else if (door_open) begin
        door_len++;
      end
      if (!door_open && door_prev) chk("door_len", door_len, exp_len);
      door_prev = door_open;
    end
  end

  task automatic push_stop(input int f, input int c, input int l);
    stop_t e;
    e.floor = f;
    e.cyc   = c;
    e.len   = l;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    call_req = '0;
    @(negedge clk);
    @(negedge clk);
    sb_q.delete();
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [FLOORS-1:0] m);
    call_req = m;
    @(negedge clk);
    call_req = '0;
  endtask

  int c0;
  int c1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);

    // Reset state and basic up trip 0 -> 2
    do_reset();
    chk("rst_floor", current_floor, 0);
    chk("rst_pending", pending, 0);
    chk("rst_moving", moving, 0);
    chk("rst_door", door_open, 0);
    chk("rst_up", up_led, 0);
    chk("rst_down", down_led, 0);
    c0 = cyc;
    push_stop(2, c0 + 9, 3);
    pulse(4'b0100);
    chk("s1_moving", moving, 1);
    chk("s1_up", up_led, 1);
    chk("s1_down", down_led, 0);
    chk("s1_floor0", current_floor, 0);
    repeat (4) @(negedge clk);
    chk("s1_floor1", current_floor, 1);
    chk("s1_moving_f1", moving, 1);
    repeat (4) @(negedge clk);
    chk("s1_floor2", current_floor, 2);
    chk("s1_door", door_open, 1);
    chk("s1_stopped", moving, 0);
    chk("s1_up_off", up_led, 0);
    repeat (4) @(negedge clk);
    chk("s1_door_closed", door_open, 0);
    chk("s1_pending", pending, 0);
    chk("s1_q_empty", sb_q.size(), 0);

    // Stop en route: heading to 3, call for 2 arrives before reaching it
    do_reset();
    c0 = cyc;
    push_stop(2, c0 + 9, 3);
    push_stop(3, c0 + 17, 3);
    pulse(4'b1000);
    repeat (2) @(negedge clk);
    pulse(4'b0100);
    chk("s2_pending", pending, 4'b1100);
    repeat (18) @(negedge clk);
    chk("s2_floor", current_floor, 3);
    chk("s2_pending_end", pending, 0);
    chk("s2_q_empty", sb_q.size(), 0);

    // Direction retention: door at 1 going up with calls at 0 and 3
    do_reset();
    c0 = cyc;
    push_stop(1, c0 + 5, 3);
    push_stop(3, c0 + 17, 3);
    push_stop(0, c0 + 33, 3);
    pulse(4'b0010);
    repeat (4) @(negedge clk);
    chk("s3_door_f1", door_open, 1);
    pulse(4'b1001);
    chk("s3_pending", pending, 4'b1001);
    repeat (3) @(negedge clk);
    chk("s3_up_leg", up_led, 1);
    chk("s3_no_down", down_led, 0);
    repeat (11) @(negedge clk);
    chk("s3_at_top", current_floor, 3);
    chk("s3_down_seen_early", down_seen, 0);
    @(negedge clk);
    chk("s3_down_leg", down_led, 1);
    chk("s3_up_off", up_led, 0);
    repeat (15) @(negedge clk);
    chk("s3_floor0", current_floor, 0);
    chk("s3_pending_end", pending, 0);
    chk("s3_q_empty", sb_q.size(), 0);

    // Same-floor call with a dwell-extending repeat in the 2nd door cycle
    do_reset();
    c0 = cyc;
    push_stop(2, c0 + 9, 3);
    pulse(4'b0100);
    repeat (11) @(negedge clk);
    c1 = cyc;
    push_stop(2, c1 + 1, 5);
    pulse(4'b0100);
    chk("s4_door", door_open, 1);
    chk("s4_no_move", moving, 0);
    chk("s4_floor", current_floor, 2);
    @(negedge clk);
    pulse(4'b0100);
    chk("s4_not_latched", pending, 0);
    repeat (4) @(negedge clk);
    chk("s4_door_closed", door_open, 0);
    chk("s4_q_empty", sb_q.size(), 0);

    // All floors called at once from floor 0
    do_reset();
    c0 = cyc;
    push_stop(0, c0 + 1, 3);
    push_stop(1, c0 + 9, 3);
    push_stop(2, c0 + 17, 3);
    push_stop(3, c0 + 25, 3);
    pulse(4'b1111);
    chk("s5_door_f0", door_open, 1);
    chk("s5_pending", pending, 4'b1110);
    repeat (30) @(negedge clk);
    chk("s5_max_floor", max_floor, FLOORS - 1);
    chk("s5_no_down", down_seen, 0);
    chk("s5_floor", current_floor, 3);
    chk("s5_pending_end", pending, 0);
    chk("s5_q_empty", sb_q.size(), 0);

    // Reset during a move (second leg, tcnt=2) with calls presented alongside
    do_reset();
    pulse(4'b0100);
    repeat (6) @(negedge clk);
    chk("s6_floor_pre", current_floor, 1);
    chk("s6_moving_pre", moving, 1);
    rst      = 1'b1;
    call_req = '1;
    @(negedge clk);
    chk("s6_floor", current_floor, 0);
    chk("s6_pending", pending, 0);
    chk("s6_moving", moving, 0);
    chk("s6_up", up_led, 0);
    chk("s6_down", down_led, 0);
    chk("s6_door", door_open, 0);
    rst      = 1'b0;
    call_req = '0;
    repeat (3) @(negedge clk);
    chk("s6_idle_moving", moving, 0);
    chk("s6_idle_door", door_open, 0);
    chk("s6_idle_pending", pending, 0);
    chk("s6_q_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
